// File: rtl/tm_clause_scheduler.sv
// Time-multiplexed Tsetlin Machine clause evaluator: walks class/clause/chunk,
// fetches exclude bits one chunk at a time, accumulates signed class sums and reports the argmax.
module tm_clause_scheduler #(
    parameter int CHUNK_W     = 32,
    parameter int NUM_CHUNKS  = 4,
    parameter int NUM_CLAUSES = 16,
    parameter int NUM_CLASSES = 10,
    parameter int AW          = $clog2(NUM_CLASSES * NUM_CLAUSES * NUM_CHUNKS),
    parameter int SUM_W       = $clog2(NUM_CLAUSES) + 2,
    parameter int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] features,
    output logic                          busy,
    output logic                          ex_rd_en,
    output logic [AW-1:0]                 ex_rd_addr,
    input  logic [2*CHUNK_W-1:0]          ex_rd_data,
    output logic                          sum_valid,
    output logic [CLS_W-1:0]              sum_class,
    output logic signed [SUM_W-1:0]       sum_value,
    output logic                          done,
    output logic [CLS_W-1:0]              pred_class
);

    localparam int KW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int LW = $clog2(NUM_CLAUSES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EVAL,
        S_ACCUM,
        S_CLASS_END,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CLS_W-1:0]         class_q, class_d;
    logic [LW-1:0]            clause_q, clause_d;
    logic [KW-1:0]            chunk_q, chunk_d;
    logic                     acc_q, acc_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic signed [SUM_W-1:0]  max_q, max_d;
    logic [CLS_W-1:0]         max_idx_q, max_idx_d;
    logic [CLS_W-1:0]         pred_q, pred_d;

    logic [CHUNK_W-1:0] chunk_arr [NUM_CHUNKS];
    logic [CHUNK_W-1:0] f_chunk;
    logic [CHUNK_W-1:0] ex_pos;
    logic [CHUNK_W-1:0] ex_neg;
    logic               chunk_ok;
    logic               last_chunk;
    logic               last_clause;
    logic               last_class;
    logic               take_max;

    generate
        for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
            assign chunk_arr[gi] = features[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

    assign f_chunk  = chunk_arr[chunk_q];
    assign ex_pos   = ex_rd_data[2*CHUNK_W-1:CHUNK_W];
    assign ex_neg   = ex_rd_data[CHUNK_W-1:0];
    // A literal survives if it is excluded or its feature value satisfies it.
    assign chunk_ok = (&(ex_pos | f_chunk)) & (&(ex_neg | ~f_chunk));

    assign last_chunk  = (chunk_q == KW'(NUM_CHUNKS - 1));
    assign last_clause = (clause_q == LW'(NUM_CLAUSES - 1));
    assign last_class  = (class_q == CLS_W'(NUM_CLASSES - 1));
    // Class 0 always seeds the running max; later classes must be strictly larger.
    assign take_max    = (class_q == '0) || (sum_q > max_q);

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        clause_d  = clause_q;
        chunk_d   = chunk_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        pred_d    = pred_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    class_d   = '0;
                    clause_d  = '0;
                    chunk_d   = '0;
                    sum_d     = '0;
                    max_d     = '0;
                    max_idx_d = '0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                acc_d = ((chunk_q == '0) ? 1'b1 : acc_q) & chunk_ok;
                if (!chunk_ok || last_chunk) begin
                    state_d = S_ACCUM;
                end else begin
                    chunk_d = chunk_q + KW'(1);
                    state_d = S_READ;
                end
            end
            S_ACCUM: begin
                if (acc_q) begin
                    sum_d = clause_q[0] ? (sum_q - SUM_W'(1)) : (sum_q + SUM_W'(1));
                end
                chunk_d = '0;
                if (last_clause) begin
                    state_d = S_CLASS_END;
                end else begin
                    clause_d = clause_q + LW'(1);
                    state_d  = S_READ;
                end
            end
            S_CLASS_END: begin
                if (take_max) begin
                    max_d     = sum_q;
                    max_idx_d = class_q;
                end
                sum_d    = '0;
                clause_d = '0;
                if (last_class) begin
                    pred_d  = take_max ? class_q : max_idx_q;
                    state_d = S_DONE;
                end else begin
                    class_d = class_q + CLS_W'(1);
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            class_q   <= '0;
            clause_q  <= '0;
            chunk_q   <= '0;
            acc_q     <= 1'b0;
            sum_q     <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
            pred_q    <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            clause_q  <= clause_d;
            chunk_q   <= chunk_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            pred_q    <= pred_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign ex_rd_en   = (state_q == S_READ);
    assign ex_rd_addr = (AW'(class_q) * AW'(NUM_CLAUSES) + AW'(clause_q)) * AW'(NUM_CHUNKS)
                        + AW'(chunk_q);
    assign sum_valid  = (state_q == S_CLASS_END);
    assign sum_class  = class_q;
    assign sum_value  = sum_q;
    assign done       = (state_q == S_DONE);
    assign pred_class = pred_q;

endmodule
